// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program-memory responder and the MCU top level.
//   state_e    : responder FSM states (idle / loading an image / MCU running)
//   DefaultAw  : MCU address width (MEM_ADDR)
//   DefaultDw  : MCU data width
package prog_mem_pkg;

  localparam int unsigned DefaultAw = 5;
  localparam int unsigned DefaultDw = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } state_e;

endpackage

// File: rtl/prog_mem_responder_if.sv
// Bus bundle between the MCU / program loader (master) and the memory responder (slave).
//   addr, read, write, wr_data, mem_data_out : MCU memory bus
//   ld_start, ld_valid, ld_data, ld_last     : loader byte stream into the responder
//   ld_ready                                 : responder accepts the next loader byte
interface prog_mem_responder_if
  import prog_mem_pkg::*;
#(
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned DW = DefaultDw
) ();

  logic [AW-1:0] addr;
  logic          read;
  logic          write;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem_data_out;

  logic          ld_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;

  modport master (
    output addr, read, write, wr_data, ld_start, ld_valid, ld_data, ld_last,
    input  mem_data_out, ld_ready
  );

  modport slave (
    input  addr, read, write, wr_data, ld_start, ld_valid, ld_data, ld_last,
    output mem_data_out, ld_ready
  );

endinterface

// File: rtl/mem_array_1r1w.sv
// DEPTH x DW storage with one asynchronous read port and one synchronous write port.
// The write port is shared by the program loader and the MCU; the two enables are
// mutually exclusive by construction in the responder FSM, loader wins if both rise.
//   clk                       : write clock
//   ld_we/ld_addr/ld_data     : loader write request
//   cpu_we/cpu_addr/cpu_data  : MCU write request
//   raddr/rdata               : combinational read port
// Contents are never cleared; there is deliberately no reset.
module mem_array_1r1w #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic          clk,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_data,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  always_comb begin
    we    = ld_we | cpu_we;
    waddr = cpu_addr;
    wdata = cpu_data;
    if (ld_we) begin
      waddr = ld_addr;
      wdata = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Async read: a same-cycle write to raddr is only visible after the edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem_responder.sv
// Memory-side responder for the accumulator MCU bus, with a byte-stream program loader.
//   clk, reset  : system clock, synchronous active-high reset
//   bus         : MCU bus + loader handshake (slave side)
//   cpu_hold    : hold MCU in reset while idle or loading
//   load_busy   : FSM is loading an image
//   load_done   : sticky, last load finished normally
//   bus_err     : sticky, MCU raised read and write together while running
module prog_mem_responder
  import prog_mem_pkg::*;
#(
  parameter int unsigned AW    = DefaultAw,
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  prog_mem_responder_if.slave  bus,
  output logic                 cpu_hold,
  output logic                 load_busy,
  output logic                 load_done,
  output logic                 bus_err
);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          ld_ready_q;
  logic          cpu_hold_q;
  logic          load_busy_q;
  logic          load_done_q;
  logic          bus_err_q;

  logic          in_run;
  logic          ld_fire;
  logic          cnt_at_end;
  logic          cpu_we;
  logic [DW-1:0] rdata;

  assign in_run     = (state_q == StRun);
  assign ld_fire    = (state_q == StLoad) && bus.ld_valid && ld_ready_q;
  assign cnt_at_end = (cnt_q == AW'(DEPTH - 1));
  // Simultaneous read and write is illegal: the read is served, the write dropped.
  assign cpu_we     = in_run && bus.write && !bus.read;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ld_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      load_busy_q <= 1'b0;
      load_done_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.ld_start) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            ld_ready_q  <= 1'b1;
            cpu_hold_q  <= 1'b1;
            load_busy_q <= 1'b1;
            load_done_q <= 1'b0;
          end
        end
        StLoad: begin
          if (ld_fire) begin
            if (bus.ld_last || cnt_at_end) begin
              // Counter is left where it is so it never wraps past DEPTH-1.
              state_q     <= StRun;
              ld_ready_q  <= 1'b0;
              cpu_hold_q  <= 1'b0;
              load_busy_q <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.read && bus.write) begin
            bus_err_q <= 1'b1;
          end
          if (bus.ld_start) begin
            state_q     <= StLoad;
            cnt_q       <= '0;
            ld_ready_q  <= 1'b1;
            cpu_hold_q  <= 1'b1;
            load_busy_q <= 1'b1;
            load_done_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          ld_ready_q  <= 1'b0;
          cpu_hold_q  <= 1'b1;
          load_busy_q <= 1'b0;
        end
      endcase
    end
  end

  mem_array_1r1w #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .ld_we    (ld_fire),
    .ld_addr  (cnt_q),
    .ld_data  (bus.ld_data),
    .cpu_we   (cpu_we),
    .cpu_addr (bus.addr),
    .cpu_data (bus.wr_data),
    .raddr    (bus.addr),
    .rdata    (rdata)
  );

  // Zero-latency read so the MCU can latch data in the same cycle it strobes READ.
  assign bus.mem_data_out = (in_run && bus.read) ? rdata : '0;
  assign bus.ld_ready     = ld_ready_q;
  assign cpu_hold         = cpu_hold_q;
  assign load_busy        = load_busy_q;
  assign load_done        = load_done_q;
  assign bus_err          = bus_err_q;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Directed bench for prog_mem_responder: table of MCU bus vectors plus hand-written
// sequences for loading, illegal accesses and reset in the middle of a load.
module tb_prog_mem_responder;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_hold, load_busy, load_done, bus_err;

  int n_chk = 0;
  int n_fail = 0;

  prog_mem_responder_if #(.AW(AW), .DW(DW)) bus ();

  prog_mem_responder #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_busy (load_busy),
    .load_done (load_done),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic hold, input logic rdy,
                            input logic busy, input logic done, input logic err);
    chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
    chk({tag, ".ld_ready"}, 32'(bus.ld_ready), 32'(rdy));
    chk({tag, ".load_busy"}, 32'(load_busy), 32'(busy));
    chk({tag, ".load_done"}, 32'(load_done), 32'(done));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(err));
  endtask

  // Combinational read; no clock edge consumed.
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
    bus.addr = a;
    bus.read = 1'b1;
    #1;
    chk(nm, 32'(bus.mem_data_out), 32'(exp));
    bus.read = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic pulse_start();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  initial begin
    vt[0] = '{rd: 1'b1, wr: 1'b0, addr: 5'd0, wd: 8'h00, exp: 8'hA1};
    vt[1] = '{rd: 1'b1, wr: 1'b0, addr: 5'd1, wd: 8'h00, exp: 8'hB2};
    vt[2] = '{rd: 1'b1, wr: 1'b0, addr: 5'd2, wd: 8'h00, exp: 8'hC3};
    vt[3] = '{rd: 1'b1, wr: 1'b0, addr: 5'd3, wd: 8'h00, exp: 8'hD4};
    vt[4] = '{rd: 1'b0, wr: 1'b1, addr: 5'd2, wd: 8'h55, exp: 8'h00};
    vt[5] = '{rd: 1'b1, wr: 1'b0, addr: 5'd2, wd: 8'h00, exp: 8'h55};
    vt[6] = '{rd: 1'b0, wr: 1'b0, addr: 5'd5, wd: 8'h00, exp: 8'h00};
    vt[7] = '{rd: 1'b0, wr: 1'b1, addr: 5'd4, wd: 8'h77, exp: 8'h00};
    vt[8] = '{rd: 1'b1, wr: 1'b0, addr: 5'd4, wd: 8'h00, exp: 8'h77};

    bus.addr = '0; bus.read = 1'b0; bus.write = 1'b0; bus.wr_data = '0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;

    // Reset, then idle with strobes active: everything must stay quiet.
    tick(); tick();
    chk_status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    bus.read = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_status($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("idle%0d.mem_data_out", i), 32'(bus.mem_data_out), 32'h0);
    end
    bus.read = 1'b0;

    // Short load with valid gaps carrying junk data.
    pulse_start();
    chk_status("load4.start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'hA1, 1'b0);
    bus.ld_data = 8'hEE; tick();
    send(8'hB2, 1'b0);
    bus.ld_data = 8'hEE; tick(); tick();
    send(8'hC3, 1'b0);
    bus.ld_data = 8'hEE; tick();
    chk_status("load4.mid", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'hD4, 1'b1);
    chk_status("load4.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Table of MCU bus accesses in RUN.
    for (int i = 0; i < 9; i++) begin
      bus.read    = vt[i].rd;
      bus.write   = vt[i].wr;
      bus.addr    = vt[i].addr;
      bus.wr_data = vt[i].wd;
      #1;
      chk($sformatf("vec%0d.mem_data_out", i), 32'(bus.mem_data_out), 32'(vt[i].exp));
      tick();
      bus.read  = 1'b0;
      bus.write = 1'b0;
    end
    chk("vec.bus_err", 32'(bus_err), 32'h0);

    // Illegal read+write: read served with old data, write dropped, error sticky.
    bus.read = 1'b1; bus.write = 1'b1; bus.addr = 5'd3; bus.wr_data = 8'h99;
    #1;
    chk("rw.mem_data_out", 32'(bus.mem_data_out), 32'hD4);
    tick();
    bus.read = 1'b0; bus.write = 1'b0;
    chk("rw.bus_err", 32'(bus_err), 32'h1);
    rd(5'd3, 8'hD4, "rw.mem3");
    tick(); tick();
    chk("rw.bus_err_sticky", 32'(bus_err), 32'h1);

    // Full 32-byte load without ld_last; ld_start mid-load must be ignored.
    pulse_start();
    chk_status("full.start", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.read = 1'b1; bus.addr = 5'd2;
    for (int i = 0; i < 32; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'(8'h40 + i);
      bus.ld_start = (i == 16);
      #1;
      if (i == 5) chk("full.read_ignored", 32'(bus.mem_data_out), 32'h0);
      if (i == 31) chk("full.busy_at31", 32'(load_busy), 32'h1);
      tick();
    end
    bus.ld_start = 1'b0;
    bus.read = 1'b0;
    bus.ld_data = 8'hEE;
    chk_status("full.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    bus.ld_valid = 1'b0;
    rd(5'd0, 8'h40, "full.mem0");
    rd(5'd2, 8'h42, "full.mem2");
    rd(5'd16, 8'h50, "full.mem16");
    rd(5'd17, 8'h51, "full.mem17");
    rd(5'd31, 8'h5F, "full.mem31");

    // Reset after 10 of 20 bytes: partial image retained, then reload from 0.
    pulse_start();
    for (int i = 0; i < 10; i++) send(8'(8'h60 + i), 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_status("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.read = 1'b1; bus.write = 1'b1; bus.addr = 5'd12; bus.wr_data = 8'h11;
    #1;
    chk("rst_mid.idle_read", 32'(bus.mem_data_out), 32'h0);
    tick();
    bus.read = 1'b0; bus.write = 1'b0;
    chk("rst_mid.idle_err", 32'(bus_err), 32'h0);
    pulse_start();
    bus.write = 1'b1; bus.addr = 5'd13; bus.wr_data = 8'h22;
    send(8'h70, 1'b1);
    bus.write = 1'b0;
    chk_status("reload.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(5'd0, 8'h70, "reload.mem0");
    for (int i = 1; i < 10; i++) rd(5'(i), 8'(8'h60 + i), $sformatf("reload.mem%0d", i));
    rd(5'd10, 8'h4A, "reload.mem10");
    rd(5'd12, 8'h4C, "reload.mem12");
    rd(5'd13, 8'h4D, "reload.mem13");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
